// File: rtl/cbist_controller_if.sv
// rtl/cbist_controller_if.sv - circular-BIST controller handshake bundle (bist_abort only with CBIST_ABORT_EN)
interface cbist_controller_if #(
  parameter int SIG_WIDTH = 16
);
  logic                 bist_start;
  logic [SIG_WIDTH-1:0] sig_in;
`ifdef CBIST_ABORT_EN
  logic                 bist_abort;
`endif
  logic                 test_mode;
  logic                 chain_en;
  logic                 chain_init;
  logic                 busy;
  logic                 bist_end;
  logic                 pass_fail;
  logic [SIG_WIDTH-1:0] signature_out;

  // Controller side: consumes the request and live signature, drives chain control and results.
  modport master (
    input  bist_start,
    input  sig_in,
`ifdef CBIST_ABORT_EN
    input  bist_abort,
`endif
    output test_mode,
    output chain_en,
    output chain_init,
    output busy,
    output bist_end,
    output pass_fail,
    output signature_out
  );

  // Host/chain side: the mirror image of the controller.
  modport slave (
    output bist_start,
    output sig_in,
`ifdef CBIST_ABORT_EN
    output bist_abort,
`endif
    input  test_mode,
    input  chain_en,
    input  chain_init,
    input  busy,
    input  bist_end,
    input  pass_fail,
    input  signature_out
  );
endinterface

// File: rtl/cbist_controller.sv
// rtl/cbist_controller.sv - circular-BIST sequencer: seed, run, freeze, compare; CBIST_ABORT_EN adds bist_abort
module cbist_controller #(
  parameter int                   N_CYCLES   = 1000,
  parameter int                   SIG_WIDTH  = 16,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG = 16'h0000,
  parameter int                   CNT_WIDTH  = $clog2(N_CYCLES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  cbist_controller_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    COMPARE,
    DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(N_CYCLES - 1);

  state_t               state;
  state_t               next_state;
  logic                 start_q;
  logic                 start;
  logic [CNT_WIDTH-1:0] cnt;

  logic                 test_mode;
  logic                 chain_en;
  logic                 chain_init;
  logic                 busy;
  logic                 clr_result;
  logic                 load_result;
  logic                 result_pass;
  logic                 cnt_inc;

  logic                 end_r;
  logic                 pass_r;
  logic [SIG_WIDTH-1:0] sig_r;

  // History resets high so a request already held during reset is not seen as an edge.
  assign start = bus.bist_start & ~start_q;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Start-edge history.
  always_ff @(posedge clock) begin
    if (reset) start_q <= 1'b1;
    else       start_q <= bus.bist_start;
  end

  // Run counter: cleared when a run is launched, stops advancing at the last RUN cycle.
  always_ff @(posedge clock) begin
    if (reset)           cnt <= '0;
    else if (clr_result) cnt <= '0;
    else if (cnt_inc)    cnt <= cnt + CNT_WIDTH'(1);
  end

  // Result registers: cleared on launch, loaded when leaving COMPARE (or on abort), held otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      end_r  <= 1'b0;
      pass_r <= 1'b0;
      sig_r  <= '0;
    end else if (clr_result) begin
      end_r  <= 1'b0;
      pass_r <= 1'b0;
      sig_r  <= '0;
    end else if (load_result) begin
      end_r  <= 1'b1;
      pass_r <= result_pass;
      sig_r  <= bus.sig_in;
    end
  end

  // Next-state logic plus Moore decode of the chain controls from the current state.
  always_comb begin
    next_state  = state;
    test_mode   = 1'b0;
    chain_en    = 1'b1;
    chain_init  = 1'b0;
    busy        = 1'b0;
    clr_result  = 1'b0;
    load_result = 1'b0;
    result_pass = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = INIT;
          clr_result = 1'b1;
        end
      end
      INIT: begin
        test_mode  = 1'b1;
        chain_init = 1'b1;
        busy       = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        test_mode = 1'b1;
        busy      = 1'b1;
        if (cnt == CNT_LAST) next_state = COMPARE;
        else                 cnt_inc    = 1'b1;
      end
      COMPARE: begin
        test_mode   = 1'b1;
        chain_en    = 1'b0;
        busy        = 1'b1;
        next_state  = DONE;
        load_result = 1'b1;
        result_pass = (bus.sig_in == GOLDEN_SIG);
      end
      default: next_state = IDLE;
    endcase
`ifdef CBIST_ABORT_EN
    // Abort overrides both the normal RUN exit and the COMPARE verdict.
    if (busy && bus.bist_abort) begin
      next_state  = DONE;
      load_result = 1'b1;
      result_pass = 1'b0;
      cnt_inc     = 1'b0;
    end
`endif
  end

  assign bus.test_mode     = test_mode;
  assign bus.chain_en      = chain_en;
  assign bus.chain_init    = chain_init;
  assign bus.busy          = busy;
  assign bus.bist_end      = end_r;
  assign bus.pass_fail     = pass_r;
  assign bus.signature_out = sig_r;

endmodule

// File: tb/tb_cbist_controller.sv
// tb/tb_cbist_controller.sv - directed vector bench for cbist_controller (abort case with CBIST_ABORT_EN)
module tb_cbist_controller;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  cbist_controller_if #(.SIG_WIDTH(16)) bus ();
  cbist_controller_if #(.SIG_WIDTH(16)) bus1 ();

  cbist_controller #(
    .N_CYCLES  (8),
    .SIG_WIDTH (16),
    .GOLDEN_SIG(16'hA5C3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  cbist_controller #(
    .N_CYCLES  (1),
    .SIG_WIDTH (16),
    .GOLDEN_SIG(16'h00FF)
  ) dut1 (
    .clock(clock),
    .reset(reset),
    .bus  (bus1)
  );

  typedef struct {
    logic        rst;
    logic        start;
    logic [15:0] sig;
    logic [21:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected output word: {test_mode, chain_en, chain_init, busy, bist_end, pass_fail, signature_out}
  function automatic logic [21:0] e(input logic tm, input logic ce, input logic ci, input logic bz,
                                    input logic be, input logic pf, input logic [15:0] so);
    return {tm, ce, ci, bz, be, pf, so};
  endfunction

  function automatic logic [21:0] outs();
    return {bus.test_mode, bus.chain_en, bus.chain_init, bus.busy,
            bus.bist_end, bus.pass_fail, bus.signature_out};
  endfunction

  function automatic void add(input logic rst, input logic start, input logic [15:0] sig,
                              input logic [21:0] exp);
    vec_t v;
    v.rst   = rst;
    v.start = start;
    v.sig   = sig;
    v.exp   = exp;
    tbl.push_back(v);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Launch one run on dut; lat = edges from the start-sampling edge to bist_end, -1 on timeout.
  task automatic run_timed(input logic [15:0] sig, output int lat);
    bus.bist_start = 1'b0;
    bus.sig_in     = sig;
    step();
    bus.bist_start = 1'b1;
    step();
    bus.bist_start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus.bist_end === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int first;
    int ci_cnt;
    logic stray;

    reset           = 1'b1;
    bus.bist_start  = 1'b0;
    bus.sig_in      = '0;
    bus1.bist_start = 1'b0;
    bus1.sig_in     = '0;
`ifdef CBIST_ABORT_EN
    bus.bist_abort  = 1'b0;
    bus1.bist_abort = 1'b0;
`endif

    // Passing run, then a failing rerun launched from DONE.
    add(1, 0, 16'h0000, e(0, 1, 0, 0, 0, 0, 16'h0000));
    add(1, 0, 16'h0000, e(0, 1, 0, 0, 0, 0, 16'h0000));
    add(0, 0, 16'h0000, e(0, 1, 0, 0, 0, 0, 16'h0000));
    add(0, 1, 16'h1111, e(1, 1, 1, 1, 0, 0, 16'h0000));
    add(0, 0, 16'h1111, e(1, 1, 0, 1, 0, 0, 16'h0000));
    for (int i = 0; i < 7; i++) add(0, 0, 16'h1111, e(1, 1, 0, 1, 0, 0, 16'h0000));
    add(0, 0, 16'h1111, e(1, 0, 0, 1, 0, 0, 16'h0000));
    add(0, 0, 16'hA5C3, e(0, 1, 0, 0, 1, 1, 16'hA5C3));
    add(0, 0, 16'h0000, e(0, 1, 0, 0, 1, 1, 16'hA5C3));
    add(0, 1, 16'h0000, e(1, 1, 1, 1, 0, 0, 16'h0000));
    add(0, 1, 16'h0000, e(1, 1, 0, 1, 0, 0, 16'h0000));
    for (int i = 0; i < 7; i++) add(0, 0, 16'h0000, e(1, 1, 0, 1, 0, 0, 16'h0000));
    add(0, 0, 16'h0000, e(1, 0, 0, 1, 0, 0, 16'h0000));
    add(0, 0, 16'hA5C2, e(0, 1, 0, 0, 1, 0, 16'hA5C2));

    for (int i = 0; i < tbl.size(); i++) begin
      reset          = tbl[i].rst;
      bus.bist_start = tbl[i].start;
      bus.sig_in     = tbl[i].sig;
      step();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // Start held 3 cycles plus a pulse during RUN: one run only.
    bus.sig_in = 16'hA5C3;
    ci_cnt = 0;
    first  = -1;
    for (int k = 1; k <= 14; k++) begin
      bus.bist_start = (k <= 3 || k == 6);
      step();
      if (bus.chain_init === 1'b1) ci_cnt++;
      if (k > 1 && bus.bist_end === 1'b1 && first < 0) first = k;
    end
    check("held_start_latency", 32'(first), 32'd11);
    check("held_start_init_pulses", 32'(ci_cnt), 32'd1);
    check("held_start_done", 32'(outs()), 32'(e(0, 1, 0, 0, 1, 1, 16'hA5C3)));

    // Reset with start rising together from DONE, start held across reset release.
    bus.bist_start = 1'b1;
    reset = 1'b1;
    step();
    check("reset_clears_done", 32'(outs()), 32'(e(0, 1, 0, 0, 0, 0, 16'h0000)));
    step();
    reset = 1'b0;
    stray = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.busy !== 1'b0 || bus.chain_init !== 1'b0 || bus.test_mode !== 1'b0) stray = 1'b1;
    end
    check("start_held_over_reset", 32'(stray), 32'd0);

    // Reset during RUN cycle 4, then a fresh run.
    bus.bist_start = 1'b0;
    bus.sig_in     = 16'hA5C3;
    step();
    bus.bist_start = 1'b1;
    step();
    bus.bist_start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("run_before_reset", 32'(outs()), 32'(e(1, 1, 0, 1, 0, 0, 16'h0000)));
    reset = 1'b1;
    step();
    check("reset_mid_run", 32'(outs()), 32'(e(0, 1, 0, 0, 0, 0, 16'h0000)));
    reset = 1'b0;
    run_timed(16'h0000, lat);
    check("rerun_latency", 32'(lat), 32'd10);
    check("rerun_result", 32'(outs()), 32'(e(0, 1, 0, 0, 1, 0, 16'h0000)));

    // Single-cycle RUN instance.
    bus1.sig_in     = 16'h00FF;
    bus1.bist_start = 1'b1;
    step();
    bus1.bist_start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus1.bist_end === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("n1_latency", 32'(lat), 32'd3);
    check("n1_pass", 32'({bus1.pass_fail, bus1.signature_out}), 32'({1'b1, 16'h00FF}));

`ifdef CBIST_ABORT_EN
    // Abort during RUN cycle 3.
    bus.sig_in     = 16'h0000;
    bus.bist_start = 1'b0;
    step();
    bus.bist_start = 1'b1;
    step();
    bus.bist_start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    bus.bist_abort = 1'b1;
    bus.sig_in     = 16'h1234;
    step();
    bus.bist_abort = 1'b0;
    check("abort_result", 32'(outs()), 32'(e(0, 1, 0, 0, 1, 0, 16'h1234)));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cbist_controller.md
Name: cbist_controller

Overview:
- Sequencer for the circular-BIST chain wrapped around the 4-requester round-robin arbiter in top.
- On a bist_start rising edge it:
  - seeds the circular chain,
  - runs it in test mode for a fixed cycle count,
  - freezes it and captures the 16-bit signature,
  - compares the signature against a golden value.
- Reports the result on bist_end / pass_fail / signature_out and returns the chain to functional mode.

Parameters:
- N_CYCLES, 1000, number of RUN cycles; must be >= 1.
- SIG_WIDTH, 16, width of the chain signature.
- GOLDEN_SIG, 16'h0000, expected fault-free signature. Overridden per netlist from the getvalidsignature run.
- CNT_WIDTH, $clog2(N_CYCLES+1), width of the run counter.

Ports:
- clock  input  1  single system clock; all state on posedge.
- reset  input  1  synchronous, active-high reset.
- bist_start  input  1  level request; only a rising edge launches a run.
- sig_in  input  SIG_WIDTH  live signature from the circular chain.
- test_mode  output  1  1 = chain muxed into circular BIST mode; 0 = functional.
- chain_en  output  1  chain register clock enable.
- chain_init  output  1  load chain with seed (1-cycle pulse).
- busy  output  1  high in INIT/RUN/COMPARE.
- bist_end  output  1  run complete, result valid.
- pass_fail  output  1  1 = signature matched GOLDEN_SIG; valid only while bist_end=1.
- signature_out  output  SIG_WIDTH  captured signature.

Behaviour:
- Clock and reset:
  - Single clock, clock.
  - reset is synchronous and active-high.
  - All outputs are registered or decoded Moore-style from registered state; there are no combinational paths from inputs to outputs.
- Reset values:
  - State = IDLE, counter = 0.
  - test_mode = 0, chain_en = 1, chain_init = 0, busy = 0.
  - bist_end = 0, pass_fail = 0, signature_out = 0.
  - Start-edge history register (bist_start_q) = 1, so bist_start held high through reset does not launch a run.
- Start detect: start = bist_start & ~bist_start_q.
  - Honoured only in IDLE and DONE.
  - Ignored in INIT, RUN and COMPARE.
- IDLE: test_mode = 0, chain_en = 1. start -> INIT.
- INIT (exactly 1 cycle):
  - Outputs: test_mode = 1, chain_en = 1, chain_init = 1, busy = 1.
  - Cleared on entry: bist_end, pass_fail, signature_out, counter.
  - Next state: RUN.
- RUN:
  - Outputs: test_mode = 1, chain_en = 1, chain_init = 0.
  - Counter increments each cycle.
  - On the edge where counter == N_CYCLES-1 -> COMPARE, so RUN lasts exactly N_CYCLES cycles.
- COMPARE (exactly 1 cycle):
  - Outputs: test_mode = 1, chain_en = 0 (chain frozen, sig_in stable).
  - At the exiting edge: signature_out <= sig_in; pass_fail <= (sig_in == GOLDEN_SIG); bist_end <= 1.
  - Next state: DONE.
- DONE:
  - Outputs: test_mode = 0, chain_en = 1, busy = 0.
  - bist_end, pass_fail and signature_out are held.
  - start -> INIT, which drops bist_end the next cycle.
- Latency: start-sampling edge to bist_end = 1 is exactly N_CYCLES + 2 cycles.
- Boundary conditions:
  - N_CYCLES = 1 gives a single RUN cycle.
  - The counter never wraps; it saturates at N_CYCLES-1.
  - reset mid-run returns to IDLE on the next edge with reset values; the chain returns to functional mode and no result is reported.
  - start and reset asserted together: reset wins.

Optional Feature:
- Macro: CBIST_ABORT_EN.
- When defined:
  - Adds input bist_abort (1 bit).
  - bist_abort = 1 in INIT, RUN or COMPARE -> DONE on the next edge.
  - On abort: bist_end = 1, pass_fail = 0 forced, signature_out = sig_in at the abort edge.
  - Abort has priority over start and over normal RUN->COMPARE; reset has priority over abort.
- When undefined:
  - The port does not exist.
  - Behaviour is exactly as above.

Test Plan:
- N_CYCLES=8, GOLDEN_SIG=16'hA5C3:
  - Reset 2 cycles, then pulse bist_start, with sig_in=16'hA5C3 during COMPARE -> chain_init high for 1 cycle, test_mode high for 10 cycles, chain_en low for 1 cycle, bist_end rises exactly 10 cycles after the start edge, pass_fail=1, signature_out=16'hA5C3.
- Same run, sig_in=16'hA5C2 -> bist_end=1, pass_fail=0, signature_out=16'hA5C2.
- bist_start held high 3 cycles plus a second pulse during RUN -> exactly one run; bist_end at cycle 10; no extra chain_init.
- reset asserted at RUN cycle 4 -> next cycle: IDLE, test_mode=0, busy=0, bist_end=0, signature_out=0. A fresh start completes in 10 cycles.
- From DONE (pass_fail=1), new start with sig_in=16'h0000 -> bist_end drops 1 cycle later, rerun completes with pass_fail=0. Also: bist_start held high across reset release -> no run launched.
- CBIST_ABORT_EN defined, bist_abort pulsed at RUN cycle 3 with sig_in=16'h1234 -> bist_end=1, pass_fail=0, signature_out=16'h1234 next cycle, test_mode=0.
